// File: rtl/lib_pkg.sv
// Shared LSU types: FSM state encoding, load funct3 codes and access-size decode.
package lib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A nonzero store mask wins over the load type when both are present.
  function automatic acc_size_t size_of(input logic [3:0] wr_en, input logic [2:0] funct3);
    if (wr_en != 4'b0000)
      return (wr_en == 4'b1111) ? SZ_W : (wr_en == 4'b0011) ? SZ_H : SZ_B;
    return funct3[1] ? SZ_W : funct3[0] ? SZ_H : SZ_B;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-oriented data memory port between the LSU (master) and the memory (slave).
// Handshake: master raises mem_req with mem_addr/mem_be/mem_we/mem_wdata and holds them
// stable until the slave returns mem_ack for one cycle; mem_rdata is valid in that ack cycle.
interface dmem_lsu_if #(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
);
  logic             mem_req;
  logic             mem_we;
  logic [DADDR-3:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_ext.sv
// Picks the byte/halfword at the lane offset out of a read word and sign/zero extends it.
module load_ext
  import lib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       off,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = 8'(word >> {off, 3'b000});
  assign h = 16'(word >> {off, 3'b000});

  always_comb begin
    ext = word;
    case (funct3)
      F3_LB:   ext = {{(WIDTH-8){b[7]}}, b};
      F3_LH:   ext = {{(WIDTH-16){h[15]}}, h};
      F3_LBU:  ext = {{(WIDTH-8){1'b0}}, b};
      F3_LHU:  ext = {{(WIDTH-16){1'b0}}, h};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one outstanding access, IDLE -> BUSY -> DONE, stalls the pipeline meanwhile.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of aligning them.
module dmem_lsu
  import lib_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DADDR-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       wr_en,
  input  logic             ld_req,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             misalign,
  dmem_lsu_if.master       mem,
  output lsu_state_t       dbg_state
);

  lsu_state_t       state, state_nx;
  acc_size_t        size;
  logic             is_store, req, trap, accept;
  logic [1:0]       off;
  logic [3:0]       lane_be;
  logic [WIDTH-1:0] lane_data, ext;

  logic [DADDR-3:0] waddr_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [3:0]       be_q;
  logic [WIDTH-1:0] wdata_q, rdata_q;
  logic             we_q;

  assign is_store = |wr_en;
  assign req      = is_store | ld_req;
  assign size     = size_of(wr_en, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign off  = addr[1:0];
  assign trap = reset_n && (state == IDLE) && req &&
                (((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00)));
`else
  // Misaligned halfword/word accesses silently drop the offending low address bits.
  assign off  = (size == SZ_W) ? 2'b00 : (size == SZ_H) ? {addr[1], 1'b0} : addr[1:0];
  assign trap = 1'b0;
`endif

  // reset_n gates the combinational outputs so everything reads 0 while reset is held.
  assign accept    = reset_n && (state == IDLE) && req && !trap;
  assign lane_be   = is_store ? (wr_en << off) : 4'b1111;
  assign lane_data = is_store ? (wdata << {off, 3'b000}) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (mem.mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        waddr_q <= addr[DADDR-1:2];
        off_q   <= off;
        f3_q    <= funct3;
        be_q    <= lane_be;
        wdata_q <= lane_data;
        we_q    <= is_store;
      end
      if ((state == BUSY) && mem.mem_ack) rdata_q <= mem.mem_rdata;
    end
  end

  load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .word   (rdata_q),
    .off    (off_q),
    .funct3 (f3_q),
    .ext    (ext)
  );

  assign mem.mem_req   = (state == BUSY);
  assign mem.mem_we    = (state == BUSY) && we_q;
  assign mem.mem_addr  = (state == BUSY) ? waddr_q : '0;
  assign mem.mem_be    = (state == BUSY) ? be_q : 4'b0000;
  assign mem.mem_wdata = (state == BUSY) ? wdata_q : '0;

  assign stall     = accept || (state == BUSY);
  assign misalign  = trap;
  assign rdata     = ((state == DONE) && !we_q) ? ext : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, hand-written corner sequences, random traffic vs model.
module tb_dmem_lsu;
  import lib_pkg::*;

  localparam int WIDTH = 32;
  localparam int DADDR = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [DADDR-1:0] addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [3:0]       wr_en = '0;
  logic             ld_req = 1'b0;
  logic [2:0]       funct3 = '0;
  logic [WIDTH-1:0] rdata;
  logic             stall;
  logic             misalign;
  lsu_state_t       dbg_state;

  dmem_lsu_if #(.WIDTH(WIDTH), .DADDR(DADDR)) mem_if ();

  dmem_lsu #(.WIDTH(WIDTH), .DADDR(DADDR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wdata     (wdata),
    .wr_en     (wr_en),
    .ld_req    (ld_req),
    .funct3    (funct3),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .mem       (mem_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wr_en;
    logic        ld_req;
    logic [2:0]  funct3;
    int          delay;
    logic [31:0] mem_word;
    logic        exp_trap;
    logic [7:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] we,
                              input logic ld, input logic [2:0] f3, input int dly,
                              input logic [31:0] word, input logic trap, input logic [7:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic [31:0] erd, input int est);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wr_en = we; v.ld_req = ld; v.funct3 = f3; v.delay = dly;
    v.mem_word = word; v.exp_trap = trap; v.exp_addr = ea; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_stall = est;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t        r = v;
    bit          st = (v.wr_en != 4'h0);
    bit          sgn = (v.funct3 < 3'd4);
    int          size, off;
    logic [31:0] part;
    if (st) size = (v.wr_en == 4'hF) ? 4 : (v.wr_en == 4'h3) ? 2 : 1;
    else    size = (v.funct3 == 3'd2) ? 4 : (v.funct3 == 3'd1 || v.funct3 == 3'd5) ? 2 : 1;
    off = int'(v.addr) % 4;
`ifdef LSU_MISALIGN_TRAP_EN
    r.exp_trap = (off % size) != 0;
`else
    r.exp_trap = 1'b0;
    off = off - (off % size);
`endif
    r.exp_addr  = 8'(v.addr / 4);
    r.exp_be    = st ? 4'((int'(v.wr_en) * (1 << off)) % 16) : 4'hF;
    r.exp_wdata = st ? 32'(64'(v.wdata) * (64'd1 << (8 * off))) : 32'h0;
    part = v.mem_word / (32'd1 << (8 * off));
    if (st) r.exp_rdata = 32'h0;
    else if (size == 4) r.exp_rdata = v.mem_word;
    else if (size == 2) begin
      r.exp_rdata = part % 65536;
      if (sgn && r.exp_rdata >= 32768) r.exp_rdata = r.exp_rdata + 32'hFFFF0000;
    end else begin
      r.exp_rdata = part % 256;
      if (sgn && r.exp_rdata >= 128) r.exp_rdata = r.exp_rdata + 32'hFFFFFF00;
    end
    r.exp_stall = r.exp_trap ? 0 : v.delay + 1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ld_req = 1'b0; wr_en = 4'h0; addr = '0; wdata = '0; funct3 = '0;
  endtask

  task automatic run_txn(input vec_t v, input bit hold_in_done);
    int stall_cnt = 0;
    bit st = (v.wr_en != 4'h0);
    @(negedge clk);
    addr = v.addr; wdata = v.wdata; wr_en = v.wr_en; ld_req = v.ld_req; funct3 = v.funct3;
    #1;
    if (v.exp_trap) begin
      chk("trap_misalign", misalign, 1);
      chk("trap_stall", stall, 0);
      @(negedge clk);
      clear_inputs();
      #1;
      chk("trap_no_req", mem_if.mem_req, 0);
      chk("trap_state", dbg_state, IDLE);
      chk("trap_misalign_drop", misalign, 0);
      return;
    end
    chk("req_misalign", misalign, 0);
    if (stall) stall_cnt++;
    exp_q.push_back(v.exp_rdata);
    for (int k = 1; k <= v.delay; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      #1;
      chk("busy_req", mem_if.mem_req, 1);
      chk("busy_addr", 32'(mem_if.mem_addr), 32'(v.exp_addr));
      chk("busy_be", 32'(mem_if.mem_be), 32'(v.exp_be));
      chk("busy_we", mem_if.mem_we, 32'(st));
      if (st) chk("busy_wdata", mem_if.mem_wdata, v.exp_wdata);
      chk("busy_rdata_zero", rdata, 0);
      if (stall) stall_cnt++;
      mem_if.mem_ack   = (k == v.delay);
      mem_if.mem_rdata = (k == v.delay) ? v.mem_word : $urandom;
    end
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = $urandom;
    if (hold_in_done) begin
      addr = 10'h010; funct3 = F3_LW; ld_req = 1'b1;
    end
    #1;
    if (stall) stall_cnt++;
    chk("done_state", dbg_state, DONE);
    chk("done_req", mem_if.mem_req, 0);
    chk("done_rdata", rdata, exp_q.pop_front());
    chk("stall_cycles", stall_cnt, v.exp_stall);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("after_rdata_zero", rdata, 0);
    chk("after_state_idle", dbg_state, IDLE);
    chk("after_no_req", mem_if.mem_req, 0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[10];
  vec_t v;

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;

    tbl[0] = mk(10'h008, 32'hDEADBEEF, 4'hF, 0, F3_LB,  1, 32'h0,        0, 8'h02, 4'hF, 32'hDEADBEEF, 32'h0,        2);
    tbl[1] = mk(10'h00B, 32'h000000A5, 4'h1, 0, F3_LB,  1, 32'h0,        0, 8'h02, 4'h8, 32'hA5000000, 32'h0,        2);
    tbl[2] = mk(10'h002, 32'h0,        4'h0, 1, F3_LB,  1, 32'h0080FF00, 0, 8'h00, 4'hF, 32'h0,        32'hFFFFFF80, 2);
    tbl[3] = mk(10'h002, 32'h0,        4'h0, 1, F3_LBU, 2, 32'h0080FF00, 0, 8'h00, 4'hF, 32'h0,        32'h00000080, 3);
    tbl[4] = mk(10'h000, 32'h0,        4'h0, 1, F3_LH,  5, 32'h0080FF00, 0, 8'h00, 4'hF, 32'h0,        32'hFFFFFF00, 6);
    tbl[5] = mk(10'h012, 32'h0,        4'h0, 1, F3_LHU, 1, 32'h80011234, 0, 8'h04, 4'hF, 32'h0,        32'h00008001, 2);
    tbl[6] = mk(10'h006, 32'h0000BEEF, 4'h3, 0, F3_LB,  2, 32'h0,        0, 8'h01, 4'hC, 32'hBEEF0000, 32'h0,        3);
    tbl[7] = mk(10'h3FC, 32'h0,        4'h0, 1, F3_LW,  3, 32'h12345678, 0, 8'hFF, 4'hF, 32'h0,        32'h12345678, 4);
    tbl[8] = mk(10'h001, 32'h0000005A, 4'h1, 1, F3_LW,  1, 32'hFFFFFFFF, 0, 8'h00, 4'h2, 32'h00005A00, 32'h0,        2);
    tbl[9] = mk(10'h003, 32'h0,        4'h0, 1, F3_LB,  1, 32'h7F000000, 0, 8'h00, 4'hF, 32'h0,        32'h0000007F, 2);

    // Reset with a request present: every output must read 0.
    #1 reset_n = 1'b0;
    ld_req = 1'b1; wr_en = 4'hF; addr = 10'h3FF; funct3 = F3_LW;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_we", mem_if.mem_we, 0);
    chk("rst_addr", 32'(mem_if.mem_addr), 0);
    chk("rst_be", 32'(mem_if.mem_be), 0);
    chk("rst_wdata", mem_if.mem_wdata, 0);
    chk("rst_state", dbg_state, IDLE);
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i], 1'b0);

    // mem_ack while idle must be ignored.
    @(negedge clk);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    chk("idle_ack_state", dbg_state, IDLE);
    chk("idle_ack_rdata", rdata, 0);
    chk("idle_ack_stall", stall, 0);
    mem_if.mem_ack = 1'b0;

    // A request present during DONE is not accepted.
    v.addr = 10'h024; v.wdata = 0; v.wr_en = 4'h0; v.ld_req = 1; v.funct3 = F3_LH;
    v.delay = 2; v.mem_word = 32'h8765_4321;
    run_txn(model(v), 1'b1);

    // Reset asserted mid-access drops mem_req at once; then a fresh LW completes.
    @(negedge clk);
    addr = 10'h010; funct3 = F3_LW; ld_req = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1 chk("pre_rst_busy_req", mem_if.mem_req, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_req", mem_if.mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_state", dbg_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(mk(10'h010, 32'h0, 4'h0, 1, F3_LW, 1, 32'h0BADC0DE, 0, 8'h04, 4'hF, 32'h0, 32'h0BADC0DE, 2), 1'b0);

    // LW at a non-word-aligned address.
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn(mk(10'h006, 32'h0, 4'h0, 1, F3_LW, 1, 32'h11223344, 1, 8'h00, 4'h0, 32'h0, 32'h0, 0), 1'b0);
`else
    run_txn(mk(10'h006, 32'h0, 4'h0, 1, F3_LW, 1, 32'h11223344, 0, 8'h01, 4'hF, 32'h0, 32'h11223344, 2), 1'b0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      v.addr = 10'($urandom_range(0, 1023));
      v.wdata = $urandom;
      v.mem_word = $urandom;
      v.delay = $urandom_range(1, 4);
      case ($urandom_range(0, 4))
        0, 1: v.wr_en = 4'h0;
        2:    v.wr_en = 4'h1;
        3:    v.wr_en = 4'h3;
        default: v.wr_en = 4'hF;
      endcase
      v.ld_req = (v.wr_en == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: v.funct3 = F3_LB;
        1: v.funct3 = F3_LH;
        2: v.funct3 = F3_LW;
        3: v.funct3 = F3_LBU;
        default: v.funct3 = F3_LHU;
      endcase
      run_txn(model(v), (i % 7) == 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
